// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared MDIO frame encodings, field widths and FSM states
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_WDATA,
    S_RDATA
  } mdio_state_t;

  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] ST_PATTERN = 2'b01;

  localparam int ST_W    = 2;
  localparam int OP_W    = 2;
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int TA_W    = 2;
  localparam int DATA_W  = 16;

  function automatic logic op_valid(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/mdio_responder_if.sv
// rtl/mdio_responder_if.sv - MDIO line and register-port bundle between initiator and responder
interface mdio_responder_if;
  import mdio_pkg::*;

  logic                 mdc;
  logic                 mdio_out;
  logic                 mdio_oe;
  logic                 mdio_in;
  logic                 resp_oe;
  logic [REGAD_W-1:0]   reg_addr;
  logic [DATA_W-1:0]    wr_data;
  logic                 wr_stb;
  logic                 rd_stb;
  logic [DATA_W-1:0]    rd_data;
  logic                 frame_err;

  modport master (
    output mdc, mdio_out, mdio_oe, rd_data,
    input  mdio_in, resp_oe, reg_addr, wr_data, wr_stb, rd_stb, frame_err
  );

  modport slave (
    input  mdc, mdio_out, mdio_oe, rd_data,
    output mdio_in, resp_oe, reg_addr, wr_data, wr_stb, rd_stb, frame_err
  );

endinterface

// File: rtl/mdio_edge_det.sv
// rtl/mdio_edge_det.sv - registers mdc and produces one-clk rise/fall pulses
module mdio_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  output logic rise,
  output logic fall
);

  logic mdc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_d <= 1'b0;
    end else begin
      mdc_d <= mdc;
    end
  end

  assign rise = mdc & ~mdc_d;
  assign fall = ~mdc & mdc_d;

endmodule

// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - MDIO frame responder; define MDIO_PHYAD_CHECK_EN to answer only PHY_ADDR
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'h15
) (
  input logic            clk,
  input logic            reset,
  mdio_responder_if.slave bus
);

  logic              rise;
  logic              fall;
  logic              sample;
  logic              phy_ok;
  mdio_state_t       state;
  logic [4:0]        cnt;
  logic [4:0]        fld;
  logic [4:0]        fld_next;
  logic [15:0]       shreg;
  logic [15:0]       shreg_next;
  logic              op_rd;
  logic              rd_pend;
  logic              mdio_in_r;
  logic              resp_oe_r;
  logic              wr_stb_r;
  logic              rd_stb_r;
  logic              frame_err_r;
  logic [4:0]        reg_addr_r;
  logic [15:0]       wr_data_r;

  mdio_edge_det u_edge_det (
    .clk   (clk),
    .reset (reset),
    .mdc   (bus.mdc),
    .rise  (rise),
    .fall  (fall)
  );

  assign sample     = rise & bus.mdio_oe;
  assign fld_next   = {fld[3:0], bus.mdio_out};
  assign shreg_next = {shreg[14:0], bus.mdio_out};

`ifdef MDIO_PHYAD_CHECK_EN
  assign phy_ok = (fld_next == PHY_ADDR);
`else
  // PHYAD is still shifted in, but every address is accepted
  assign phy_ok = (fld_next == PHY_ADDR) | 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      fld         <= '0;
      shreg       <= '0;
      op_rd       <= 1'b0;
      rd_pend     <= 1'b0;
      mdio_in_r   <= 1'b0;
      resp_oe_r   <= 1'b0;
      wr_stb_r    <= 1'b0;
      rd_stb_r    <= 1'b0;
      frame_err_r <= 1'b0;
      reg_addr_r  <= '0;
      wr_data_r   <= '0;
    end else begin
      wr_stb_r    <= 1'b0;
      frame_err_r <= 1'b0;
      rd_stb_r    <= rd_pend;
      rd_pend     <= 1'b0;
      // Register file answers one clk after rd_stb; capture it here
      if (rd_stb_r) shreg <= bus.rd_data;

      if (!bus.mdio_oe && (state inside {S_ST, S_OP, S_PHYAD, S_REGAD, S_WDATA})) begin
        frame_err_r <= 1'b1;
        state       <= S_IDLE;
        cnt         <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (sample && bus.mdio_out == ST_PATTERN[1]) state <= S_ST;
          end
          S_ST: begin
            if (sample && bus.mdio_out == ST_PATTERN[0]) begin
              state <= S_OP;
              cnt   <= '0;
            end
          end
          S_OP: begin
            if (sample) begin
              fld <= fld_next;
              if (cnt == 5'(OP_W - 1)) begin
                cnt <= '0;
                if (op_valid(fld_next[1:0])) begin
                  op_rd <= (fld_next[1:0] == OP_READ);
                  state <= S_PHYAD;
                end else begin
                  frame_err_r <= 1'b1;
                  state       <= S_IDLE;
                end
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          S_PHYAD: begin
            if (sample) begin
              fld <= fld_next;
              if (cnt == 5'(PHYAD_W - 1)) begin
                cnt   <= '0;
                state <= phy_ok ? S_REGAD : S_IDLE;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          S_REGAD: begin
            if (sample) begin
              fld <= fld_next;
              if (cnt == 5'(REGAD_W - 1)) begin
                cnt        <= '0;
                reg_addr_r <= fld_next;
                rd_pend    <= op_rd;
                state      <= S_TA;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          S_TA: begin
            // Read turnaround is paced by falls since the responder owns the line
            if (op_rd) begin
              if (fall) begin
                resp_oe_r <= 1'b1;
                mdio_in_r <= 1'b0;
                if (cnt == 5'(TA_W - 1)) begin
                  cnt   <= '0;
                  state <= S_RDATA;
                end else begin
                  cnt <= cnt + 5'd1;
                end
              end
            end else if (rise) begin
              if (cnt == 5'(TA_W - 1)) begin
                cnt   <= '0;
                state <= S_WDATA;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          S_WDATA: begin
            if (sample) begin
              shreg <= shreg_next;
              if (cnt == 5'(DATA_W - 1)) begin
                cnt       <= '0;
                wr_data_r <= shreg_next;
                wr_stb_r  <= 1'b1;
                state     <= S_IDLE;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          S_RDATA: begin
            if (fall) begin
              if (cnt == 5'(DATA_W)) begin
                resp_oe_r <= 1'b0;
                mdio_in_r <= 1'b0;
                cnt       <= '0;
                state     <= S_IDLE;
              end else begin
                mdio_in_r <= shreg[15];
                shreg     <= {shreg[14:0], 1'b0};
                cnt       <= cnt + 5'd1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.mdio_in   = mdio_in_r;
  assign bus.resp_oe   = resp_oe_r;
  assign bus.wr_stb    = wr_stb_r;
  assign bus.rd_stb    = rd_stb_r;
  assign bus.frame_err = frame_err_r;
  assign bus.reg_addr  = reg_addr_r;
  assign bus.wr_data   = wr_data_r;

endmodule

// File: tb/tb_mdio_responder.sv
// tb/tb_mdio_responder.sv - randomized MDIO initiator with register-file model for mdio_responder
module tb_mdio_responder;
  import mdio_pkg::*;

  localparam logic [4:0] PHY = 5'h15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdio_responder_if bus ();

  mdio_responder #(.PHY_ADDR(PHY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] regs [32];
  int          hi_ph, lo_ph;
  logic [31:0] rx_bits, rx_oe;
  logic        post_oe, post_in;
  int          n_wr, n_rd, n_err, n_both;
  logic [4:0]  wr_addr_seen, rd_addr_seen;
  logic [15:0] wr_data_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor plus the external register file answering rd_stb one clk later
  initial begin
    n_both = 0;
    forever begin
      @(negedge clk);
      if (bus.wr_stb) begin
        n_wr++;
        wr_addr_seen = bus.reg_addr;
        wr_data_seen = bus.wr_data;
      end
      if (bus.rd_stb) begin
        n_rd++;
        rd_addr_seen = bus.reg_addr;
      end
      if (bus.frame_err) n_err++;
      if (bus.wr_stb && bus.rd_stb) n_both++;
      bus.rd_data = bus.rd_stb ? regs[bus.reg_addr] : 16'($urandom);
    end
  end

  task automatic drive_bit(input logic b, input logic oe, input int idx);
    bus.mdc      = 1'b0;
    bus.mdio_out = oe ? b : 1'($urandom);
    bus.mdio_oe  = oe;
    repeat (lo_ph) @(negedge clk);
    rx_bits[idx] = bus.mdio_in;
    rx_oe[idx]   = bus.resp_oe;
    bus.mdc = 1'b1;
    repeat (hi_ph) @(negedge clk);
  endtask

  task automatic run_frame(input logic [31:0] f, input int n_oe);
    n_wr = 0; n_rd = 0; n_err = 0;
    repeat ($urandom_range(0, 3)) drive_bit(1'b1, 1'b1, 0);
    for (int i = 0; i < 32; i++) drive_bit(f[31-i], (i < n_oe), i);
    bus.mdc     = 1'b0;
    bus.mdio_oe = 1'b0;
    repeat (lo_ph) @(negedge clk);
    post_oe = bus.resp_oe;
    post_in = bus.mdio_in;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] f, input string tag);
    logic [4:0]  ra;
    logic [15:0] d;
    ra = f[22:18];
    d  = f[15:0];
    run_frame(f, 32);
    check({tag, ".wr_cnt"}, n_wr, 1);
    check({tag, ".rd_cnt"}, n_rd, 0);
    check({tag, ".err_cnt"}, n_err, 0);
    check({tag, ".wr_addr"}, wr_addr_seen, ra);
    check({tag, ".wr_data"}, wr_data_seen, d);
    check({tag, ".resp_oe"}, rx_oe, 0);
    regs[ra] = d;
  endtask

  task automatic do_read(input logic [31:0] f, input string tag);
    logic [4:0]  ra;
    logic [15:0] word;
    ra = f[22:18];
    run_frame(f, 14);
    for (int k = 0; k < 16; k++) word[15-k] = rx_bits[16+k];
    check({tag, ".rd_cnt"}, n_rd, 1);
    check({tag, ".wr_cnt"}, n_wr, 0);
    check({tag, ".err_cnt"}, n_err, 0);
    check({tag, ".rd_addr"}, rd_addr_seen, ra);
    check({tag, ".ta_zero"}, rx_bits[15], 1'b0);
    check({tag, ".data"}, word, regs[ra]);
    check({tag, ".oe_window"}, rx_oe, 32'hFFFF_C000);
    check({tag, ".oe_end"}, {post_oe, post_in}, 2'b00);
  endtask

  initial begin
    logic [31:0] fr;
    reset        = 1'b1;
    bus.mdc      = 1'b0;
    bus.mdio_out = 1'b0;
    bus.mdio_oe  = 1'b0;
    hi_ph = 1;
    lo_ph = 1;
    for (int i = 0; i < 32; i++) regs[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    check("reset.outs", {bus.reg_addr, bus.wr_data, bus.wr_stb, bus.rd_stb,
                         bus.frame_err, bus.resp_oe, bus.mdio_in}, 0);
    reset = 1'b0;
    @(negedge clk);

    do_write(32'h5AB87654, "w_fixed");
    regs[5'h0E] = 16'hBEEF;
    do_read(32'h6AB80000, "r_fixed");

    fr = {ST_PATTERN, OP_WRITE, 5'h03, 5'h1F, 2'b11, 16'hFFFF};
`ifdef MDIO_PHYAD_CHECK_EN
    run_frame(fr, 32);
    check("phy_other.wr_cnt", n_wr, 0);
    check("phy_other.err_cnt", n_err, 0);
    check("phy_other.resp_oe", rx_oe, 0);
`else
    do_write(fr, "phy_other");
`endif

    run_frame(32'h7FFF_FFFF, 32);
    check("op11.err_cnt", n_err, 1);
    check("op11.stb_cnt", n_wr + n_rd, 0);
    do_write({ST_PATTERN, OP_WRITE, PHY, 5'h07, 2'b10, 16'hA5C3}, "w_after_op11");

    run_frame({ST_PATTERN, OP_WRITE, PHY, 5'h09, 2'b10, 16'h1234}, 26);
    check("oe_drop.err_cnt", n_err, 1);
    check("oe_drop.wr_cnt", n_wr, 0);

    for (int n = 0; n < 20; n++) begin
      hi_ph = $urandom_range(1, 3);
      lo_ph = $urandom_range(1, 3);
      fr = {ST_PATTERN, OP_WRITE, PHY, 5'($urandom), 2'b10, 16'($urandom)};
      if ($urandom_range(0, 1) == 1) do_read({fr[31:30], OP_READ, fr[27:0]}, "rand_rd");
      else do_write(fr, "rand_wr");
    end

    hi_ph = 1;
    lo_ph = 1;
    do_write({ST_PATTERN, OP_WRITE, PHY, 5'h11, 2'b10, 16'hC0DE}, "b2b_wr");
    do_read({ST_PATTERN, OP_READ, PHY, 5'h11, 2'b00, 16'h0000}, "b2b_rd");

    hi_ph = 2;
    lo_ph = 2;
    regs[5'h05] = 16'hFFFF;
    fr = {ST_PATTERN, OP_READ, PHY, 5'h05, 2'b00, 16'h0000};
    n_err = 0;
    for (int i = 0; i < 23; i++) drive_bit(fr[31-i], (i < 14), i);
    check("rst_mid.before", {bus.resp_oe, bus.mdio_in}, 2'b11);
    reset   = 1'b1;
    bus.mdc = 1'b0;
    @(negedge clk);
    check("rst_mid.after", {bus.resp_oe, bus.mdio_in}, 2'b00);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid.err_cnt", n_err, 0);
    do_write({ST_PATTERN, OP_WRITE, PHY, 5'h1A, 2'b10, 16'h0F0F}, "w_after_rst");

    check("no_dual_stb", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
